// File: rtl/tpose_lane_scheduler.sv
// tpose_lane_scheduler: deals a serial row-major coefficient stream round-robin
// onto the input lanes of the transpose page. Short rows are padded with zero
// tokens, and end-of-stream is then broadcast to every lane. A single holding
// register is the only data storage, so throughput is one token per cycle and
// latency is one cycle.
module tpose_lane_scheduler #(
  parameter int W     = 16,
  parameter int LANES = 8,
  parameter int CW    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [W-1:0]       s_d,
  input  logic               s_e,
  input  logic               s_v,
  output logic               s_b,
  output logic [LANES*W-1:0] lane_d,
  output logic [LANES-1:0]   lane_e,
  output logic [LANES-1:0]   lane_v,
  input  logic [LANES-1:0]   lane_b,
  output logic [15:0]        row_cnt,
  output logic               err_part
);

  // RUN passes data through; PAD fills the rest of a short row with zeros;
  // EOSB broadcasts the end-of-stream marker to every lane.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PAD  = 2'd1,
    ST_EOSB = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_COL = CW'(LANES - 1);

  state_e           state_q,     state_d;
  logic [CW-1:0]    col_q,       col_d;
  logic             hold_v_q,    hold_v_d;
  logic [W-1:0]     hold_d_q,    hold_d_d;
  logic [CW-1:0]    hold_lane_q, hold_lane_d;
  logic [LANES-1:0] pad_mask_q,  pad_mask_d;
  logic [LANES-1:0] eos_mask_q,  eos_mask_d;
  logic [15:0]      row_cnt_q,   row_cnt_d;
  logic             err_part_q,  err_part_d;

  logic             drain;
  logic             accept;

  // Next-state logic: sequencing, column/row tracking and handshake on s.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    col_d       = col_q;
    hold_v_d    = hold_v_q;
    hold_d_d    = hold_d_q;
    hold_lane_d = hold_lane_q;
    pad_mask_d  = pad_mask_q;
    eos_mask_d  = eos_mask_q;
    row_cnt_d   = row_cnt_q;
    err_part_d  = err_part_q;
    s_b         = 1'b1;
    accept      = 1'b0;

    // The held token leaves whenever its lane is not backpressured, in any state.
    drain = hold_v_q & ~lane_b[hold_lane_q];
    if (drain) begin
      hold_v_d = 1'b0;
    end

    unique case (state_q)
      ST_RUN: begin
        // Accept only if the holding register is free by the end of this cycle.
        s_b    = hold_v_q & ~drain;
        accept = s_v & ~s_b;
        if (accept && !s_e) begin
          hold_v_d    = 1'b1;
          hold_d_d    = s_d;
          hold_lane_d = col_q;
          col_d       = col_q + 1'b1;
          if (col_q == LAST_COL) begin
            row_cnt_d = row_cnt_q + 16'd1;
          end
        end else if (accept && s_e) begin
          if (col_q == '0) begin
            state_d    = ST_EOSB;
            eos_mask_d = '1;
          end else begin
            // Lanes col..LANES-1 still owe a token for the current row.
            state_d    = ST_PAD;
            pad_mask_d = ~((LANES'(1) << col_q) - LANES'(1));
            err_part_d = 1'b1;
          end
        end
      end

      ST_PAD: begin
        // Pads go out only once the last real token has left the holding register.
        if (!hold_v_q) begin
          pad_mask_d = pad_mask_q & lane_b;
          if (pad_mask_d == '0) begin
            row_cnt_d  = row_cnt_q + 16'd1;
            col_d      = '0;
            state_d    = ST_EOSB;
            eos_mask_d = '1;
          end
        end
      end

      ST_EOSB: begin
        // EOS never overtakes pending data: wait for the holding register to empty.
        if (!hold_v_q) begin
          eos_mask_d = eos_mask_q & lane_b;
          if (eos_mask_d == '0) begin
            col_d   = '0;
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Lane outputs: the held token on its lane, otherwise pad or EOS per mask.
  always_comb begin
    lane_v = '0;
    lane_e = '0;
    lane_d = '0;
    if (hold_v_q) begin
      lane_v[hold_lane_q]                   = 1'b1;
      lane_d[int'(hold_lane_q) * W +: W]    = hold_d_q;
    end else if (state_q == ST_PAD) begin
      lane_v = pad_mask_q;
    end else if (state_q == ST_EOSB) begin
      lane_v = eos_mask_q;
      lane_e = eos_mask_q;
    end
  end

  // Control state register with synchronous, dominant reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_RUN;
      col_q       <= '0;
      hold_v_q    <= 1'b0;
      hold_lane_q <= '0;
      pad_mask_q  <= '0;
      eos_mask_q  <= '0;
      row_cnt_q   <= '0;
      err_part_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      hold_v_q    <= hold_v_d;
      hold_lane_q <= hold_lane_d;
      pad_mask_q  <= pad_mask_d;
      eos_mask_q  <= eos_mask_d;
      row_cnt_q   <= row_cnt_d;
      err_part_q  <= err_part_d;
    end
  end

  // Holding data register, qualified everywhere by hold_v_q.
  always_ff @(posedge clock) begin
    // NOTE: data storage is deliberately not reset; hold_v_q gates every use,
    // so a stale value can never reach a lane.
    hold_d_q <= hold_d_d;
  end

  assign row_cnt  = row_cnt_q;
  assign err_part = err_part_q;

endmodule

// File: tb/tb_tpose_lane_scheduler.sv
// Self-checking bench for tpose_lane_scheduler: per-lane scoreboard queues are
// filled when the serial input accepts a token and drained when a lane transfers.
module tb_tpose_lane_scheduler;

  localparam int W     = 16;
  localparam int LANES = 8;
  localparam int CW    = 3;

  logic               clock;
  logic               reset;
  logic [W-1:0]       s_d;
  logic               s_e;
  logic               s_v;
  logic               s_b;
  logic [LANES*W-1:0] lane_d;
  logic [LANES-1:0]   lane_e;
  logic [LANES-1:0]   lane_v;
  logic [LANES-1:0]   lane_b;
  logic [15:0]        row_cnt;
  logic               err_part;

  tpose_lane_scheduler #(.W(W), .LANES(LANES), .CW(CW)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_d      (s_d),
    .s_e      (s_e),
    .s_v      (s_v),
    .s_b      (s_b),
    .lane_d   (lane_d),
    .lane_e   (lane_e),
    .lane_v   (lane_v),
    .lane_b   (lane_b),
    .row_cnt  (row_cnt),
    .err_part (err_part)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard: per-lane expected {eos, data} tokens.
  logic [W:0]       lane_q [LANES][$];
  int               m_col;
  logic [15:0]      m_rows;
  bit               m_err;

  bit               mon_en;
  bit               rnd_b;
  bit               acc;
  logic             cur_sb;
  bit               sb_seen;
  int               last_acc_cyc;
  int               xfer_cyc [LANES];
  logic [LANES-1:0] prev_stall;
  logic [W-1:0]     prev_d [LANES];
  logic [LANES-1:0] prev_e;

  function automatic bit queues_empty();
    for (int i = 0; i < LANES; i++) begin
      if (lane_q[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Observe one cycle just before the rising edge: lane transfers, stalls and input acceptance.
  task automatic sample();
    logic [W:0] exp_tok;
    logic [W:0] got_tok;
    acc    = 1'b0;
    cur_sb = s_b;
    if (!mon_en) return;
    if (s_b === 1'b1) sb_seen = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      got_tok = {lane_e[i], lane_d[i*W +: W]};
      if (prev_stall[i]) begin
        checks++;
        if (lane_v[i] !== 1'b1 || got_tok !== {prev_e[i], prev_d[i]}) begin
          errors++;
          $display("FAIL stall_hold lane%0d cyc%0d: got v=%b tok=%h, required v=1 tok=%h",
                   i, cyc, lane_v[i], got_tok, {prev_e[i], prev_d[i]});
        end
      end
      if (lane_v[i] !== 1'b1) begin
        checks++;
        if (got_tok !== '0) begin
          errors++;
          $display("FAIL idle_lane_zero lane%0d cyc%0d: got %h, required 0", i, cyc, got_tok);
        end
      end else if (lane_b[i] === 1'b0) begin
        checks++;
        if (lane_q[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_token lane%0d cyc%0d: got %h, required none", i, cyc, got_tok);
        end else begin
          exp_tok = lane_q[i].pop_front();
          if (got_tok !== exp_tok) begin
            errors++;
            $display("FAIL lane_token lane%0d cyc%0d: got %h, required %h", i, cyc, got_tok, exp_tok);
          end
        end
        xfer_cyc[i] = cyc;
      end
      prev_stall[i] = (lane_v[i] === 1'b1) && (lane_b[i] === 1'b1);
      prev_d[i]     = lane_d[i*W +: W];
      prev_e[i]     = lane_e[i];
    end
    if (s_v === 1'b1 && s_b === 1'b0) begin
      acc          = 1'b1;
      last_acc_cyc = cyc;
      if (s_e) begin
        if (m_col != 0) begin
          for (int i = m_col; i < LANES; i++) lane_q[i].push_back({1'b0, {W{1'b0}}});
          m_rows = m_rows + 16'd1;
          m_err  = 1'b1;
        end
        for (int i = 0; i < LANES; i++) lane_q[i].push_back({1'b1, {W{1'b0}}});
        m_col = 0;
      end else begin
        lane_q[m_col].push_back({1'b0, s_d});
        if (m_col == LANES - 1) begin
          m_col  = 0;
          m_rows = m_rows + 16'd1;
        end else begin
          m_col++;
        end
      end
    end
  endtask

  // One clock cycle: called at the falling edge, returns at the next falling edge.
  task automatic tick();
    if (rnd_b) lane_b = LANES'($urandom_range(0, 255) & $urandom_range(0, 255));
    #3;
    sample();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    s_v    = 1'b0;
    s_e    = 1'b0;
    s_d    = '0;
    lane_b = '1;
    tick();
    reset = 1'b0;
    lane_b = '0;
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    m_col      = 0;
    m_rows     = '0;
    m_err      = 1'b0;
    prev_stall = '0;
    mon_en     = 1'b1;
  endtask

  // Present a token and hold it until accepted; s_v stays high on return.
  task automatic send(input logic [W-1:0] d, input logic e);
    s_v = 1'b1;
    s_d = d;
    s_e = e;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (acc) break;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: token %h e=%b got not accepted, required accepted", d, e);
    end
  endtask

  task automatic wait_drain(input string nm);
    bit done;
    done = 1'b0;
    s_v  = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (lane_v === '0 && queues_empty()) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got lane_v=%b still pending, required all delivered", nm, lane_v);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (lane_v !== '0)    begin errors++; $display("FAIL reset_lane_v: got %b, required 0", lane_v); end
    if (lane_e !== '0)    begin errors++; $display("FAIL reset_lane_e: got %b, required 0", lane_e); end
    if (lane_d !== '0)    begin errors++; $display("FAIL reset_lane_d: got %h, required 0", lane_d); end
    if (s_b !== 1'b0)     begin errors++; $display("FAIL reset_s_b: got %b, required 0", s_b); end
    if (row_cnt !== 16'd0) begin errors++; $display("FAIL reset_row_cnt: got %0d, required 0", row_cnt); end
    if (err_part !== 1'b0) begin errors++; $display("FAIL reset_err_part: got %b, required 0", err_part); end
  endtask

  task automatic test_stream();
    int c0;
    do_reset();
    sb_seen = 1'b0;
    send(16'h0001, 1'b0);
    c0 = last_acc_cyc;
    for (int i = 1; i < LANES; i++) send(W'(i + 1), 1'b0);
    wait_drain("stream");
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if (xfer_cyc[i] !== c0 + i + 1) begin
        errors++;
        $display("FAIL stream_latency lane%0d: got cycle %0d, required %0d", i, xfer_cyc[i], c0 + i + 1);
      end
    end
    checks += 2;
    if (sb_seen) begin errors++; $display("FAIL stream_s_b: got asserted, required never asserted"); end
    if (row_cnt !== 16'd1) begin errors++; $display("FAIL stream_row_cnt: got %0d, required 1", row_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) send(W'(i + 1), 1'b0);
    lane_b = 8'h08;
    send(16'h0004, 1'b0);
    s_d = 16'h0005;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (cur_sb !== 1'b1 || acc) begin
        errors++;
        $display("FAIL bp_stall cyc%0d: got s_b=%b acc=%b, required s_b=1 acc=0", cyc, cur_sb, acc);
      end
    end
    lane_b = '0;
    for (int i = 4; i < LANES; i++) send(W'(i + 1), 1'b0);
    wait_drain("bp");
    checks++;
    if (row_cnt !== 16'd1) begin errors++; $display("FAIL bp_row_cnt: got %0d, required 1", row_cnt); end
  endtask

  task automatic test_pad_eos();
    do_reset();
    for (int i = 0; i < 3; i++) send(W'(16'h0100 + i), 1'b0);
    send('0, 1'b1);
    wait_drain("pad");
    checks += 3;
    if (err_part !== 1'b1) begin errors++; $display("FAIL pad_err_part: got %b, required 1", err_part); end
    if (row_cnt !== 16'd1) begin errors++; $display("FAIL pad_row_cnt: got %0d, required 1", row_cnt); end
    if (s_b !== 1'b0)      begin errors++; $display("FAIL pad_run_resume: got s_b=%b, required 0", s_b); end
  endtask

  task automatic test_full_rows_eos();
    do_reset();
    for (int i = 0; i < 2 * LANES; i++) send(W'(16'h0200 + i), 1'b0);
    send('0, 1'b1);
    s_v    = 1'b0;
    lane_b = 8'h20;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (cur_sb !== 1'b1) begin
        errors++;
        $display("FAIL eos_hold_s_b cyc%0d: got %b, required 1", cyc, cur_sb);
      end
    end
    checks++;
    if (lane_q[5].size() != 1 || !(lane_q[0].size() == 0 && lane_q[7].size() == 0)) begin
      errors++;
      $display("FAIL eos_lane5_pending: got lane5 pending=%0d lane0=%0d lane7=%0d, required 1/0/0",
               lane_q[5].size(), lane_q[0].size(), lane_q[7].size());
    end
    lane_b = '0;
    tick();
    checks++;
    if (cur_sb !== 1'b1) begin errors++; $display("FAIL eos_early_run: got s_b=%b, required 1", cur_sb); end
    wait_drain("eos");
    checks += 3;
    if (err_part !== 1'b0) begin errors++; $display("FAIL eos_err_part: got %b, required 0", err_part); end
    if (row_cnt !== 16'd2) begin errors++; $display("FAIL eos_row_cnt: got %0d, required 2", row_cnt); end
    if (s_b !== 1'b0)      begin errors++; $display("FAIL eos_run_resume: got s_b=%b, required 0", s_b); end
  endtask

  task automatic test_reset_in_eosb();
    do_reset();
    for (int i = 0; i < LANES; i++) send(W'(16'h0300 + i), 1'b0);
    send('0, 1'b1);
    s_v    = 1'b0;
    lane_b = 8'hF0;
    tick();
    tick();
    checks++;
    if (lane_v !== 8'hF0 || lane_e !== 8'hF0 || cur_sb !== 1'b1) begin
      errors++;
      $display("FAIL eosb_setup: got v=%b e=%b s_b=%b, required v=11110000 e=11110000 s_b=1",
               lane_v, lane_e, cur_sb);
    end
    do_reset();
    #1;
    checks += 4;
    if (lane_v !== '0)     begin errors++; $display("FAIL rst_eosb_lane_v: got %b, required 0", lane_v); end
    if (s_b !== 1'b0)      begin errors++; $display("FAIL rst_eosb_s_b: got %b, required 0", s_b); end
    if (row_cnt !== 16'd0) begin errors++; $display("FAIL rst_eosb_row_cnt: got %0d, required 0", row_cnt); end
    if (err_part !== 1'b0) begin errors++; $display("FAIL rst_eosb_err_part: got %b, required 0", err_part); end
    send(16'hABCD, 1'b0);
    s_v = 1'b0;
    tick();
    checks++;
    if (xfer_cyc[0] !== last_acc_cyc + 1) begin
      errors++;
      $display("FAIL rst_eosb_lane0: got lane0 xfer cycle %0d, required %0d", xfer_cyc[0], last_acc_cyc + 1);
    end
    wait_drain("rst_eosb");
  endtask

  task automatic test_random();
    int n_tok;
    do_reset();
    rnd_b = 1'b1;
    n_tok = 0;
    for (int t = 0; t < 10000; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_v = 1'b0;
        tick();
      end
      send(W'($urandom), 1'b0);
      n_tok++;
      if (n_tok % 64 == 0) send('0, 1'b1);
    end
    wait_drain("random");
    rnd_b  = 1'b0;
    lane_b = '0;
    checks += 3;
    if (row_cnt !== 16'(n_tok / 8)) begin
      errors++;
      $display("FAIL random_row_cnt: got %0d, required %0d", row_cnt, n_tok / 8);
    end
    if (row_cnt !== m_rows) begin
      errors++;
      $display("FAIL random_row_model: got %0d, required %0d", row_cnt, m_rows);
    end
    if (err_part !== 1'b0) begin errors++; $display("FAIL random_err_part: got %b, required 0", err_part); end
  endtask

  initial begin
    reset  = 1'b1;
    s_d    = '0;
    s_e    = 1'b0;
    s_v    = 1'b0;
    lane_b = '0;
    mon_en = 1'b0;
    rnd_b  = 1'b0;
    prev_stall = '0;
    for (int i = 0; i < LANES; i++) xfer_cyc[i] = -1;
    @(negedge clock);
    test_reset();
    test_stream();
    test_backpressure();
    test_pad_eos();
    test_full_rows_eos();
    test_reset_in_eosb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
